// File: rtl/lfsr_src_pkg.sv
// Shared state encoding and default polynomial/seed constants for the
// LFSR operand-pair source.
package lfsr_src_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam logic [15:0] DEF_TAPS   = 16'hB400;  // x^16+x^14+x^13+x^11+1
    localparam logic [15:0] DEF_SEED_A = 16'hACE1;
    localparam logic [15:0] DEF_SEED_B = 16'h1D0F;

endpackage

// File: rtl/galois_lfsr.sv
// Right-shifting Galois LFSR with synchronous load; a zero load value is
// replaced by SEED so the register can never lock up at all-zeros.
module galois_lfsr
    import lfsr_src_pkg::*;
#(
    parameter int unsigned    W    = 16,
    parameter logic [W-1:0]   TAPS = W'(DEF_TAPS),
    parameter logic [W-1:0]   SEED = W'(DEF_SEED_A)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         step,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] state
);

    logic [W-1:0] state_q, state_d;

    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = (load_val == '0) ? SEED : load_val;
        end else if (step) begin
            state_d = (state_q >> 1) ^ (state_q[0] ? TAPS : '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/lfsr_pair_source.sv
// Length-bounded, seedable pseudo-random operand-pair source (valid/ready).
// Optional runtime seed loading is enabled by defining LFSR_SRC_SEED_LOAD_EN.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for start; LFSRs hold; seeds may be loaded
// ST_RUN  | presenting pairs; remaining counts pairs still to transfer
module lfsr_pair_source
    import lfsr_src_pkg::*;
#(
    parameter int unsigned         WIDTH  = 8,
    parameter int unsigned         LFSR_W = 16,
    parameter logic [LFSR_W-1:0]   TAPS   = LFSR_W'(DEF_TAPS),
    parameter logic [LFSR_W-1:0]   SEED_A = LFSR_W'(DEF_SEED_A),
    parameter logic [LFSR_W-1:0]   SEED_B = LFSR_W'(DEF_SEED_B),
    parameter int unsigned         CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  count,
`ifdef LFSR_SRC_SEED_LOAD_EN
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed_a,
    input  logic [LFSR_W-1:0] seed_b,
`endif
    output logic [WIDTH-1:0]  a_out,
    output logic [WIDTH-1:0]  b_out,
    output logic              valid,
    input  logic              ready,
    output logic              last,
    output logic              busy,
    output logic              done
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic               done_q, done_d;
    logic               lfsr_step;
    logic               lfsr_load;
    logic [LFSR_W-1:0]  load_a, load_b;
    logic [LFSR_W-1:0]  lfsr_a, lfsr_b;

`ifdef LFSR_SRC_SEED_LOAD_EN
    assign lfsr_load = seed_load && (state_q == ST_IDLE);
    assign load_a    = seed_a;
    assign load_b    = seed_b;
`else
    assign lfsr_load = 1'b0;
    assign load_a    = '0;
    assign load_b    = '0;
`endif

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        done_d    = 1'b0;
        lfsr_step = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (count != '0) begin
                        state_d = ST_RUN;
                        rem_d   = count;
                    end else begin
                        done_d  = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (ready) begin
                    lfsr_step = 1'b1;
                    rem_d     = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
        end
    end

    galois_lfsr #(.W(LFSR_W), .TAPS(TAPS), .SEED(SEED_A)) u_lfsr_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .step     (lfsr_step),
        .load     (lfsr_load),
        .load_val (load_a),
        .state    (lfsr_a)
    );

    galois_lfsr #(.W(LFSR_W), .TAPS(TAPS), .SEED(SEED_B)) u_lfsr_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .step     (lfsr_step),
        .load     (lfsr_load),
        .load_val (load_b),
        .state    (lfsr_b)
    );

    assign a_out = lfsr_a[WIDTH-1:0];
    assign b_out = lfsr_b[WIDTH-1:0];
    assign valid = (state_q == ST_RUN);
    assign busy  = (state_q == ST_RUN);
    assign last  = (state_q == ST_RUN) && (rem_q == CNT_W'(1));
    assign done  = done_q;

    // Upper LFSR bits feed the recurrence only; they are never presented.
    logic unused_hi;
    assign unused_hi = ^{lfsr_a[LFSR_W-1:WIDTH], lfsr_b[LFSR_W-1:WIDTH]};

endmodule

// File: tb/tb_lfsr_pair_source.sv
// Directed bench for lfsr_pair_source with hand-computed LFSR sequences.
module tb_lfsr_pair_source;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  count;
    logic [7:0]  a_out, b_out;
    logic        valid, ready, last, busy, done;
`ifdef LFSR_SRC_SEED_LOAD_EN
    logic        seed_load;
    logic [15:0] seed_a, seed_b;
`endif

    int checks = 0;
    int errors = 0;
    int xfer_cnt = 0;

    lfsr_pair_source dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .count (count),
`ifdef LFSR_SRC_SEED_LOAD_EN
        .seed_load (seed_load),
        .seed_a    (seed_a),
        .seed_b    (seed_b),
`endif
        .a_out (a_out),
        .b_out (b_out),
        .valid (valid),
        .ready (ready),
        .last  (last),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n && valid && ready) xfer_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] exp_a [3];
        logic [7:0] exp_b [3];
        logic       seen;
        exp_a[0] = 8'hE1; exp_a[1] = 8'h70; exp_a[2] = 8'h38;
        exp_b[0] = 8'h0F; exp_b[1] = 8'h87; exp_b[2] = 8'h43;

        rst_n = 1'b0; start = 1'b0; count = 8'd0; ready = 1'b0;
`ifdef LFSR_SRC_SEED_LOAD_EN
        seed_load = 1'b0; seed_a = 16'h0; seed_b = 16'h0;
`endif
        tick();
        tick();
        rst_n = 1'b1;

        // Idle after reset
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_valid", valid, 1'b0);
            chk("idle_a", a_out, 8'hE1);
            chk("idle_b", b_out, 8'h0F);
            chk("idle_busy", busy, 1'b0);
            chk("idle_done", done, 1'b0);
        end

        // Three-pair run with ready held high
        xfer_cnt = 0;
        start = 1'b1; count = 8'd3; ready = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("run3_valid", valid, 1'b1);
            chk("run3_busy", busy, 1'b1);
            chk("run3_a", a_out, exp_a[i]);
            chk("run3_b", b_out, exp_b[i]);
            chk("run3_last", last, (i == 2) ? 1'b1 : 1'b0);
            chk("run3_done_low", done, 1'b0);
            tick();
        end
        chk("run3_end_valid", valid, 1'b0);
        chk("run3_end_busy", busy, 1'b0);
        chk("run3_done", done, 1'b1);
        tick();
        chk("run3_done_pulse", done, 1'b0);
        chk("run3_xfers", xfer_cnt, 3);

        // Two-pair run with a 4-cycle stall on the final beat
        xfer_cnt = 0;
        start = 1'b1; count = 8'd2;
        tick();
        start = 1'b0;
        chk("run2_a0", a_out, 8'h9C);
        chk("run2_b0", b_out, 8'hA1);
        chk("run2_last0", last, 1'b0);
        tick();
        ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("stall_valid", valid, 1'b1);
            chk("stall_a", a_out, 8'h4E);
            chk("stall_b", b_out, 8'h50);
            chk("stall_last", last, 1'b1);
            tick();
        end
        ready = 1'b1;
        tick();
        chk("run2_done", done, 1'b1);
        chk("run2_valid_off", valid, 1'b0);
        chk("run2_xfers", xfer_cnt, 2);

        // Zero-length request
        start = 1'b1; count = 8'd0;
        tick();
        start = 1'b0;
        chk("zero_valid", valid, 1'b0);
        chk("zero_done", done, 1'b1);
        tick();
        chk("zero_done_pulse", done, 1'b0);
        chk("zero_valid2", valid, 1'b0);

        // start during RUN must not alter the run length
        xfer_cnt = 0;
        start = 1'b1; count = 8'd3;
        tick();
        start = 1'b0;
        chk("ign_a0", a_out, 8'h27);
        tick();
        start = 1'b1; count = 8'd7;
        tick();
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        chk("ign_done_seen", seen, 1'b1);
        chk("ign_xfers", xfer_cnt, 3);
        tick();
        chk("ign_no_rerun", valid, 1'b0);

        // Asynchronous reset in the middle of a five-pair run
        start = 1'b1; count = 8'd5;
        tick();
        start = 1'b0;
        chk("rst_pre_a", a_out, 8'hC4);
        tick();
        chk("rst_mid_valid", valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_valid", valid, 1'b0);
        chk("rst_last", last, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_a", a_out, 8'hE1);
        chk("rst_b", b_out, 8'h0F);
        tick();
        rst_n = 1'b1;
        start = 1'b1; count = 8'd1;
        tick();
        start = 1'b0;
        chk("rerun_a", a_out, 8'hE1);
        chk("rerun_b", b_out, 8'h0F);
        chk("rerun_last", last, 1'b1);
        tick();
        chk("rerun_done", done, 1'b1);

`ifdef LFSR_SRC_SEED_LOAD_EN
        // Zero seed falls back to the default; non-zero seed loads as given
        seed_load = 1'b1; seed_a = 16'h0000; seed_b = 16'h0001;
        tick();
        seed_load = 1'b0;
        chk("seed_a", a_out, 8'hE1);
        chk("seed_b", b_out, 8'h01);
        start = 1'b1; count = 8'd1;
        tick();
        start = 1'b0;
        chk("seed_valid", valid, 1'b1);
        tick();
        chk("seed_step_a", a_out, 8'h70);
        chk("seed_step_b", b_out, 8'h00);
`endif

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
